// File: rtl/amoa_pkg.sv
// amoa_pkg: shared definitions for the approximate multi-operand adder
// (AMOA) consumer blocks.
//   AMOA_SUM_W : width of the 8-operand adder sum.
//   AMOA_N_OPS : number of operands the adder reduces.
//   AMOA_ACC_W : default frame accumulator / result width.
//   state_t    : frame accumulator state encoding.
package amoa_pkg;

  localparam int AMOA_SUM_W = 11;
  localparam int AMOA_N_OPS = 8;
  localparam int AMOA_ACC_W = 24;

  typedef enum logic {
    ST_IDLE = 1'b0,  // no frame in progress
    ST_ACC  = 1'b1   // at least one beat of the current frame accumulated
  } state_t;

endpackage : amoa_pkg

// File: rtl/amoa_vld_pipe.sv
// amoa_vld_pipe: DEPTH-deep delay line for the operand {valid, last}
// sideband, so that it lines up with the registered adder sum.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset (clears to 0)
//   src_valid, src_last   : sideband as applied with the operands
//   dly_valid, dly_last   : sideband delayed by DEPTH cycles
module amoa_vld_pipe #(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic src_valid,
  input  logic src_last,
  output logic dly_valid,
  output logic dly_last
);

  logic [DEPTH-1:0] valid_sr;
  logic [DEPTH-1:0] last_sr;

  // NOTE: sequential state uses non-blocking assignments so every stage
  // samples the previous stage's value from before the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_sr <= '0;
      last_sr  <= '0;
    end else begin
      valid_sr[0] <= src_valid;
      last_sr[0]  <= src_last;
      for (int i = 1; i < DEPTH; i++) begin
        valid_sr[i] <= valid_sr[i-1];
        last_sr[i]  <= last_sr[i-1];
      end
    end
  end

  assign dly_valid = valid_sr[DEPTH-1];
  assign dly_last  = last_sr[DEPTH-1];

endmodule : amoa_vld_pipe

// File: rtl/amoa_acc_drain.sv
// amoa_acc_drain: accumulates consecutive AMOA sums into frame totals and
// presents each completed frame on a valid/ready port with a one-entry
// result buffer.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   op_valid, op_last   : operand beat applied to the adder / ends the frame
//   op_ready            : operand source may issue a beat this cycle
//   sum_in              : registered adder sum (ADDER_LAT cycles after op_*)
//   res_data, res_beats : completed frame total and its beat count
//   res_valid, res_ready: result handshake
//   drop_err            : sticky, a frame completed while the buffer was blocked
//   clr_err             : synchronous clear of drop_err (a new drop wins)
//   sat_flag            : only with AMOA_ACC_SAT_EN, frame total saturated
// Configuration macro: AMOA_ACC_SAT_EN selects a saturating accumulator and
// adds sat_flag; otherwise the accumulator wraps modulo 2^ACC_W.
module amoa_acc_drain
  import amoa_pkg::*;
#(
  parameter int SUM_W     = AMOA_SUM_W,
  parameter int ACC_W     = AMOA_ACC_W,
  parameter int ADDER_LAT = 1,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             op_valid,
  input  logic             op_last,
  output logic             op_ready,
  input  logic [SUM_W-1:0] sum_in,
  output logic [ACC_W-1:0] res_data,
  output logic [CNT_W-1:0] res_beats,
  output logic             res_valid,
  input  logic             res_ready,
`ifdef AMOA_ACC_SAT_EN
  output logic             sat_flag,
`endif
  output logic             drop_err,
  input  logic             clr_err
);

  logic             a_valid;
  logic             a_last;
  state_t           state, state_d;
  logic [ACC_W-1:0] acc, acc_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [ACC_W-1:0] base_acc;
  logic [CNT_W-1:0] base_cnt;
  logic [ACC_W-1:0] total;
  logic [CNT_W-1:0] beats;
  logic             complete;
  logic             blocked;
`ifdef AMOA_ACC_SAT_EN
  logic             acc_sat, acc_sat_d;
  logic             total_sat;
  logic             carry;
  logic [ACC_W-1:0] sum_wide;
`endif

  amoa_vld_pipe #(.DEPTH(ADDER_LAT)) u_vld_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .src_valid (op_valid),
    .src_last  (op_last),
    .dly_valid (a_valid),
    .dly_last  (a_last)
  );

  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    // In IDLE the frame starts from zero, so the first beat loads the sum.
    base_acc = (state == ST_ACC) ? acc : '0;
    base_cnt = (state == ST_ACC) ? cnt : '0;
`ifdef AMOA_ACC_SAT_EN
    {carry, sum_wide} = {1'b0, base_acc} + {1'b0, ACC_W'(sum_in)};
    total     = carry ? '1 : sum_wide;
    total_sat = ((state == ST_ACC) && acc_sat) || carry;
    acc_sat_d = acc_sat;
`else
    total = base_acc + ACC_W'(sum_in);
`endif
    beats    = (&base_cnt) ? base_cnt : base_cnt + CNT_W'(1);
    state_d  = state;
    acc_d    = acc;
    cnt_d    = cnt;
    complete = 1'b0;
    if (a_valid) begin
      if (a_last) begin
        // Completing beat clears the running frame so the next beat can
        // start a new frame without a bubble.
        complete = 1'b1;
        state_d  = ST_IDLE;
        acc_d    = '0;
        cnt_d    = '0;
`ifdef AMOA_ACC_SAT_EN
        acc_sat_d = 1'b0;
`endif
      end else begin
        state_d = ST_ACC;
        acc_d   = total;
        cnt_d   = beats;
`ifdef AMOA_ACC_SAT_EN
        acc_sat_d = total_sat;
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      acc   <= '0;
      cnt   <= '0;
`ifdef AMOA_ACC_SAT_EN
      acc_sat <= 1'b0;
`endif
    end else begin
      state <= state_d;
      acc   <= acc_d;
      cnt   <= cnt_d;
`ifdef AMOA_ACC_SAT_EN
      acc_sat <= acc_sat_d;
`endif
    end
  end

  assign blocked  = res_valid && !res_ready;
  assign op_ready = !blocked;

  // Result buffer: a completion loads it unless the held result is blocked,
  // in which case the new frame is dropped and flagged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid <= 1'b0;
      res_data  <= '0;
      res_beats <= '0;
      drop_err  <= 1'b0;
`ifdef AMOA_ACC_SAT_EN
      sat_flag  <= 1'b0;
`endif
    end else begin
      if (complete && !blocked) begin
        res_valid <= 1'b1;
        res_data  <= total;
        res_beats <= beats;
`ifdef AMOA_ACC_SAT_EN
        sat_flag  <= total_sat;
`endif
      end else if (res_valid && res_ready) begin
        res_valid <= 1'b0;
      end
      if (complete && blocked) begin
        drop_err <= 1'b1;
      end else if (clr_err) begin
        drop_err <= 1'b0;
      end
    end
  end

endmodule : amoa_acc_drain

// File: tb/tb_amoa_acc_drain.sv
// Testbench for amoa_acc_drain with ACC_W=12 (to reach wrap/saturation with
// a few sums), CNT_W=4 (to reach beat-count saturation) and ADDER_LAT=1.
// The adder is stood in for by a register from op_sum to sum_in.
// Build with or without AMOA_ACC_SAT_EN; expectations follow the macro.
module tb_amoa_acc_drain;

  localparam int SUM_W   = 11;
  localparam int ACC_W   = 12;
  localparam int CNT_W   = 4;
  localparam int ACC_MAX = 4095;
  localparam int CNT_MAX = 15;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             op_valid = 1'b0;
  logic             op_last = 1'b0;
  logic             op_ready;
  logic [SUM_W-1:0] op_sum = '0;
  logic [SUM_W-1:0] sum_in = '0;
  logic [ACC_W-1:0] res_data;
  logic [CNT_W-1:0] res_beats;
  logic             res_valid;
  logic             res_ready = 1'b1;
  logic             drop_err;
  logic             clr_err = 1'b0;
`ifdef AMOA_ACC_SAT_EN
  logic             sat_flag;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  amoa_acc_drain #(
    .SUM_W(SUM_W), .ACC_W(ACC_W), .ADDER_LAT(1), .CNT_W(CNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .op_valid  (op_valid),
    .op_last   (op_last),
    .op_ready  (op_ready),
    .sum_in    (sum_in),
    .res_data  (res_data),
    .res_beats (res_beats),
    .res_valid (res_valid),
    .res_ready (res_ready),
`ifdef AMOA_ACC_SAT_EN
    .sat_flag  (sat_flag),
`endif
    .drop_err  (drop_err),
    .clr_err   (clr_err)
  );

  always #5 clk = ~clk;

  // Adder stand-in: one register stage from operands to sum.
  always @(posedge clk) sum_in <= op_sum;

  // Reference model: frame totals are plain integer sums folded at the end
  // (mod 2^ACC_W or clamped), feeding a one-entry result buffer.
  logic             d_valid, d_last;
  longint           m_sum, f_sum;
  int               m_cnt, f_cnt;
  bit               m_done, m_blk;
  logic             e_valid, e_drop;
  logic [ACC_W-1:0] e_data;
  logic [CNT_W-1:0] e_beats;
`ifdef AMOA_ACC_SAT_EN
  logic             e_sat;
`endif

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_sum = 0; m_cnt = 0;
      e_valid = 1'b0; e_drop = 1'b0; e_data = '0; e_beats = '0;
`ifdef AMOA_ACC_SAT_EN
      e_sat = 1'b0;
`endif
      d_valid <= 1'b0;
      d_last  <= 1'b0;
    end else begin
      m_done = 1'b0;
      if (d_valid) begin
        m_sum += sum_in;
        m_cnt++;
        if (d_last) begin
          m_done = 1'b1; f_sum = m_sum; f_cnt = m_cnt; m_sum = 0; m_cnt = 0;
        end
      end
      m_blk = e_valid && !res_ready;
      if (m_done && !m_blk) begin
        e_valid = 1'b1;
`ifdef AMOA_ACC_SAT_EN
        e_data = ACC_W'((f_sum > ACC_MAX) ? ACC_MAX : f_sum);
        e_sat  = (f_sum > ACC_MAX);
`else
        e_data = ACC_W'(f_sum % (ACC_MAX + 1));
`endif
        e_beats = CNT_W'((f_cnt > CNT_MAX) ? CNT_MAX : f_cnt);
      end else if (e_valid && res_ready) begin
        e_valid = 1'b0;
      end
      if (m_done && m_blk) e_drop = 1'b1;
      else if (clr_err)    e_drop = 1'b0;
      d_valid <= op_valid;
      d_last  <= op_last;
    end
  end

  // Called at a falling edge: drive one cycle of operands, wait to the next
  // falling edge. Idle cycles put junk on the sum to prove it is ignored.
  task automatic beat(input logic v, input logic l, input int s);
    op_valid = v;
    op_last  = l;
    op_sum   = v ? SUM_W'(s) : SUM_W'($urandom_range(2047, 0));
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) beat(1'b0, 1'b0, 0);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    res_ready = 1'b1;
    idle(2);
    n_checks += 5;
    if (res_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", res_valid); end
    if (res_data !== '0) begin n_fail++; $display("FAIL reset_data got=%0d exp=0", res_data); end
    if (res_beats !== '0) begin n_fail++; $display("FAIL reset_beats got=%0d exp=0", res_beats); end
    if (drop_err !== 1'b0) begin n_fail++; $display("FAIL reset_drop got=%b exp=0", drop_err); end
    if (op_ready !== 1'b1) begin n_fail++; $display("FAIL reset_op_ready got=%b exp=1", op_ready); end
    rst_n = 1'b1;
    idle(1);
  endtask

  task automatic test_single_frame;
    res_ready = 1'b1;
    beat(1'b1, 1'b0, 8);
    beat(1'b1, 1'b0, 100);
    beat(1'b1, 1'b0, 2040);
    beat(1'b1, 1'b1, 3);
    n_checks++;
    if (res_valid !== 1'b0) begin n_fail++; $display("FAIL single_early_valid got=%b exp=0", res_valid); end
    idle(1);
    n_checks += 3;
    if (res_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid got=%b exp=1", res_valid); end
    if (res_data !== 12'd2151) begin n_fail++; $display("FAIL single_data got=%0d exp=2151", res_data); end
    if (res_beats !== 4'd4) begin n_fail++; $display("FAIL single_beats got=%0d exp=4", res_beats); end
    idle(1);
    n_checks++;
    if (res_valid !== 1'b0) begin n_fail++; $display("FAIL single_drained got=%b exp=0", res_valid); end
  endtask

  task automatic test_back_to_back;
    res_ready = 1'b1;
    beat(1'b1, 1'b1, 2047);
    beat(1'b1, 1'b0, 1);
    n_checks += 2;
    if (res_data !== 12'd2047) begin n_fail++; $display("FAIL b2b_first_data got=%0d exp=2047", res_data); end
    if (res_beats !== 4'd1) begin n_fail++; $display("FAIL b2b_first_beats got=%0d exp=1", res_beats); end
    beat(1'b1, 1'b1, 1);
    idle(1);
    n_checks += 3;
    if (res_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_second_valid got=%b exp=1", res_valid); end
    if (res_data !== 12'd2) begin n_fail++; $display("FAIL b2b_second_data got=%0d exp=2", res_data); end
    if (res_beats !== 4'd2) begin n_fail++; $display("FAIL b2b_second_beats got=%0d exp=2", res_beats); end
    idle(1);
  endtask

  task automatic test_blocked;
    res_ready = 1'b0;
    beat(1'b1, 1'b0, 20);
    beat(1'b1, 1'b1, 30);
    idle(1);
    n_checks += 2;
    if (res_data !== 12'd50) begin n_fail++; $display("FAIL blk_a_data got=%0d exp=50", res_data); end
    if (op_ready !== 1'b0) begin n_fail++; $display("FAIL blk_op_ready got=%b exp=0", op_ready); end
    beat(1'b1, 1'b0, 30);
    beat(1'b1, 1'b1, 40);
    idle(2);
    n_checks += 4;
    if (res_valid !== 1'b1) begin n_fail++; $display("FAIL blk_valid got=%b exp=1", res_valid); end
    if (res_data !== 12'd50) begin n_fail++; $display("FAIL blk_kept_data got=%0d exp=50", res_data); end
    if (drop_err !== 1'b1) begin n_fail++; $display("FAIL blk_drop got=%b exp=1", drop_err); end
    if (op_ready !== 1'b0) begin n_fail++; $display("FAIL blk_op_ready2 got=%b exp=0", op_ready); end
    res_ready = 1'b1;
    idle(1);
    n_checks += 3;
    if (res_valid !== 1'b0) begin n_fail++; $display("FAIL blk_xfer got=%b exp=0", res_valid); end
    if (drop_err !== 1'b1) begin n_fail++; $display("FAIL blk_sticky got=%b exp=1", drop_err); end
    if (op_ready !== 1'b1) begin n_fail++; $display("FAIL blk_op_ready3 got=%b exp=1", op_ready); end
    clr_err = 1'b1;
    idle(1);
    clr_err = 1'b0;
    n_checks++;
    if (drop_err !== 1'b0) begin n_fail++; $display("FAIL blk_clr got=%b exp=0", drop_err); end
  endtask

  task automatic test_same_cycle;
    res_ready = 1'b0;
    beat(1'b1, 1'b1, 10);
    idle(1);
    n_checks++;
    if (res_data !== 12'd10) begin n_fail++; $display("FAIL same_first got=%0d exp=10", res_data); end
    beat(1'b1, 1'b1, 20);
    res_ready = 1'b1;
    idle(1);
    n_checks += 3;
    if (res_valid !== 1'b1) begin n_fail++; $display("FAIL same_valid got=%b exp=1", res_valid); end
    if (res_data !== 12'd20) begin n_fail++; $display("FAIL same_data got=%0d exp=20", res_data); end
    if (drop_err !== 1'b0) begin n_fail++; $display("FAIL same_drop got=%b exp=0", drop_err); end
    idle(1);
  endtask

  task automatic test_wrap;
    res_ready = 1'b1;
    beat(1'b1, 1'b0, 2047);
    beat(1'b1, 1'b0, 2047);
    beat(1'b1, 1'b1, 10);
    idle(1);
    n_checks += 2;
`ifdef AMOA_ACC_SAT_EN
    if (res_data !== 12'd4095) begin n_fail++; $display("FAIL sat_data got=%0d exp=4095", res_data); end
    n_checks++;
    if (sat_flag !== 1'b1) begin n_fail++; $display("FAIL sat_flag got=%b exp=1", sat_flag); end
`else
    if (res_data !== 12'd8) begin n_fail++; $display("FAIL wrap_data got=%0d exp=8", res_data); end
`endif
    if (res_beats !== 4'd3) begin n_fail++; $display("FAIL wrap_beats got=%0d exp=3", res_beats); end
    idle(1);
  endtask

  task automatic test_cnt_sat;
    res_ready = 1'b1;
    for (int i = 0; i < 20; i++) beat(1'b1, (i == 19), 1);
    idle(1);
    n_checks += 2;
    if (res_data !== 12'd20) begin n_fail++; $display("FAIL cnt_sat_data got=%0d exp=20", res_data); end
    if (res_beats !== 4'd15) begin n_fail++; $display("FAIL cnt_sat_beats got=%0d exp=15", res_beats); end
    idle(1);
  endtask

  task automatic test_reset_mid;
    res_ready = 1'b0;
    beat(1'b1, 1'b1, 9);
    idle(1);
    beat(1'b1, 1'b1, 4);
    idle(1);
    beat(1'b1, 1'b0, 5);
    beat(1'b1, 1'b0, 5);
    n_checks++;
    if (drop_err !== 1'b1) begin n_fail++; $display("FAIL rmid_pre_drop got=%b exp=1", drop_err); end
    op_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    n_checks += 5;
    if (res_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_valid got=%b exp=0", res_valid); end
    if (res_data !== '0) begin n_fail++; $display("FAIL rmid_data got=%0d exp=0", res_data); end
    if (res_beats !== '0) begin n_fail++; $display("FAIL rmid_beats got=%0d exp=0", res_beats); end
    if (drop_err !== 1'b0) begin n_fail++; $display("FAIL rmid_drop got=%b exp=0", drop_err); end
    if (op_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_op_ready got=%b exp=1", op_ready); end
    @(negedge clk);
    idle(1);
    rst_n = 1'b1;
    res_ready = 1'b1;
    beat(1'b1, 1'b1, 7);
    idle(1);
    n_checks += 2;
    if (res_data !== 12'd7) begin n_fail++; $display("FAIL rmid_next_data got=%0d exp=7", res_data); end
    if (res_beats !== 4'd1) begin n_fail++; $display("FAIL rmid_next_beats got=%0d exp=1", res_beats); end
    idle(1);
  endtask

  task automatic test_random;
    for (int c = 0; c < 600; c++) begin
      n_checks += 2;
      if (res_valid !== e_valid) begin n_fail++; $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", c, res_valid, e_valid); end
      if (drop_err !== e_drop) begin n_fail++; $display("FAIL rnd_drop cyc=%0d got=%b exp=%b", c, drop_err, e_drop); end
      if (e_valid) begin
        n_checks += 2;
        if (res_data !== e_data) begin n_fail++; $display("FAIL rnd_data cyc=%0d got=%0d exp=%0d", c, res_data, e_data); end
        if (res_beats !== e_beats) begin n_fail++; $display("FAIL rnd_beats cyc=%0d got=%0d exp=%0d", c, res_beats, e_beats); end
`ifdef AMOA_ACC_SAT_EN
        n_checks++;
        if (sat_flag !== e_sat) begin n_fail++; $display("FAIL rnd_sat cyc=%0d got=%b exp=%b", c, sat_flag, e_sat); end
`endif
      end
      res_ready = ($urandom_range(3, 0) != 0);
      clr_err   = ($urandom_range(15, 0) == 0);
      #1;
      n_checks++;
      if (op_ready !== !(e_valid && !res_ready)) begin
        n_fail++; $display("FAIL rnd_op_ready cyc=%0d got=%b exp=%b", c, op_ready, !(e_valid && !res_ready));
      end
      // Mostly honour op_ready; occasionally ignore it to provoke drops.
      if ((op_ready || $urandom_range(7, 0) == 0) && $urandom_range(3, 0) != 0)
        beat(1'b1, ($urandom_range(4, 0) == 0), ($urandom_range(3, 0) == 0) ? 2047 : int'($urandom_range(2047, 0)));
      else
        idle(1);
    end
    clr_err = 1'b0;
    res_ready = 1'b1;
    idle(3);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_blocked();
    test_same_cycle();
    test_wrap();
    test_cnt_sat();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_amoa_acc_drain
